// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter controller.
//   pc_state_e    : FSM state encoding (RUN / HALT)
//   END_MODE_HALT : end-of-memory policy, clamp at LAST and halt
//   END_MODE_WRAP : end-of-memory policy, wrap back to RESET_ADDR
package pc_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } pc_state_e;

  localparam int END_MODE_HALT = 0;
  localparam int END_MODE_WRAP = 1;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection for pc_ctrl.
// Ports:
//   pc          in   current registered PC
//   target      in   raw redirect byte address
//   seq_pc      out  pc + INSTR_BYTES (modulo 2^WORD_LEN)
//   redir_pc    out  PC to load for a redirect (masked, clamped or wrapped)
//   redir_halt  out  redirect lands beyond LAST in halt mode
//   redir_mis   out  redirect target had nonzero sub-instruction bits
//   adv_pc      out  PC to load for a sequential advance
//   adv_halt    out  sequential advance runs off the end in halt mode
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int                  WORD_LEN    = 32,
  parameter int                  MEM_DEPTH   = 64,
  parameter int                  INSTR_BYTES = 4,
  parameter int                  END_MODE    = 0,
  parameter logic [WORD_LEN-1:0] RESET_ADDR  = '0
) (
  input  logic [WORD_LEN-1:0] pc,
  input  logic [WORD_LEN-1:0] target,
  output logic [WORD_LEN-1:0] seq_pc,
  output logic [WORD_LEN-1:0] redir_pc,
  output logic                redir_halt,
  output logic                redir_mis,
  output logic [WORD_LEN-1:0] adv_pc,
  output logic                adv_halt
);

  localparam logic [WORD_LEN-1:0] LAST     = WORD_LEN'((MEM_DEPTH - 1) * INSTR_BYTES);
  localparam logic [WORD_LEN-1:0] STRIDE   = WORD_LEN'(INSTR_BYTES);
  localparam logic [WORD_LEN-1:0] LOW_MASK = WORD_LEN'(INSTR_BYTES - 1);
  localparam logic                CLAMP    = (END_MODE == END_MODE_HALT);

  logic [WORD_LEN-1:0] masked;

  assign seq_pc    = pc + STRIDE;
  assign masked    = target & ~LOW_MASK;
  assign redir_mis = |(target & LOW_MASK);

  always_comb begin
    redir_pc   = masked;
    redir_halt = 1'b0;
    if (masked > LAST) begin
      redir_pc   = CLAMP ? LAST : RESET_ADDR;
      redir_halt = CLAMP;
    end
  end

  // ">=" also covers a RESET_ADDR configured past the end of memory.
  always_comb begin
    adv_pc   = seq_pc;
    adv_halt = 1'b0;
    if (pc >= LAST) begin
      adv_pc   = CLAMP ? LAST : RESET_ADDR;
      adv_halt = CLAMP;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller with stall, redirect, end-of-memory halt/wrap
// and a saturating retired-instruction counter.
// Ports:
//   i_CLK          in   clock, all state changes on rising edge
//   i_RST          in   synchronous active-high reset
//   i_EN           in   advance enable (low = stall)
//   i_REDIRECT     in   branch/jump taken
//   i_TARGET       in   redirect byte address
//   i_RESUME       in   leave HALT
//   o_PC           out  registered current PC
//   o_PC_NEXT_SEQ  out  o_PC + INSTR_BYTES
//   o_HALTED       out  high while halted
//   o_MISALIGNED   out  one-cycle pulse after a misaligned accepted redirect
//   o_INSTR_CNT    out  PC advances since reset (saturating)
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int                  WORD_LEN    = 32,
  parameter int                  MEM_DEPTH   = 64,
  parameter int                  INSTR_BYTES = 4,
  parameter int                  END_MODE    = 0,
  parameter logic [WORD_LEN-1:0] RESET_ADDR  = '0,
  parameter int                  CNT_W       = 16
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  input  logic                i_EN,
  input  logic                i_REDIRECT,
  input  logic [WORD_LEN-1:0] i_TARGET,
  input  logic                i_RESUME,
  output logic [WORD_LEN-1:0] o_PC,
  output logic [WORD_LEN-1:0] o_PC_NEXT_SEQ,
  output logic                o_HALTED,
  output logic                o_MISALIGNED,
  output logic [CNT_W-1:0]    o_INSTR_CNT
);

  pc_state_e           state_p1;
  logic [WORD_LEN-1:0] pc_p1;
  logic                mis_p1;
  logic [CNT_W-1:0]    cnt_p1;

  logic [WORD_LEN-1:0] seq_pc;
  logic [WORD_LEN-1:0] redir_pc;
  logic                redir_halt;
  logic                redir_mis;
  logic [WORD_LEN-1:0] adv_pc;
  logic                adv_halt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  pc_next_sel #(
    .WORD_LEN    (WORD_LEN),
    .MEM_DEPTH   (MEM_DEPTH),
    .INSTR_BYTES (INSTR_BYTES),
    .END_MODE    (END_MODE),
    .RESET_ADDR  (RESET_ADDR)
  ) u_next_sel (
    .pc         (pc_p1),
    .target     (i_TARGET),
    .seq_pc     (seq_pc),
    .redir_pc   (redir_pc),
    .redir_halt (redir_halt),
    .redir_mis  (redir_mis),
    .adv_pc     (adv_pc),
    .adv_halt   (adv_halt)
  );

  // Stage p1: PC, FSM state, misalignment pulse and counter registers
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      pc_p1    <= RESET_ADDR;
      state_p1 <= ST_RUN;
      mis_p1   <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      mis_p1 <= 1'b0;
      case (state_p1)
        ST_HALT: begin
          // Resume loads are not retirements, so the counter is untouched.
          if (i_RESUME) begin
            if (i_REDIRECT) begin
              pc_p1    <= redir_pc;
              state_p1 <= redir_halt ? ST_HALT : ST_RUN;
            end else begin
              pc_p1    <= RESET_ADDR;
              state_p1 <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (i_EN) begin
            if (i_REDIRECT) begin
              pc_p1  <= redir_pc;
              mis_p1 <= redir_mis;
              cnt_p1 <= sat_inc(cnt_p1);
              if (redir_halt) state_p1 <= ST_HALT;
            end else begin
              pc_p1 <= adv_pc;
              // Running off the end in halt mode is a hold, not an advance.
              if (adv_halt) state_p1 <= ST_HALT;
              else          cnt_p1   <= sat_inc(cnt_p1);
            end
          end
        end
        default: state_p1 <= ST_RUN;
      endcase
    end
  end

  assign o_PC          = pc_p1;
  assign o_PC_NEXT_SEQ = seq_pc;
  assign o_HALTED      = (state_p1 == ST_HALT);
  assign o_MISALIGNED  = mis_p1;
  assign o_INSTR_CNT   = cnt_p1;

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: two instances (halt mode, 16-bit counter; wrap mode,
// 3-bit counter) share one stimulus stream and are checked every cycle
// against a behavioural model plus hand-computed literals.
module tb_pc_ctrl;

  localparam logic [31:0] LAST = 32'd12;

  logic        clk;
  logic        rst;
  logic        en;
  logic        redir;
  logic        resume;
  logic [31:0] tgt;

  logic [31:0] pc_h, nxt_h, pc_w, nxt_w;
  logic        halt_h, mis_h, halt_w, mis_w;
  logic [15:0] cnt_h;
  logic [2:0]  cnt_w;

  int checks   = 0;
  int failures = 0;

  // behavioural model, index 0 = halt-mode instance, 1 = wrap-mode instance
  logic [31:0] m_pc  [2];
  bit          m_h   [2];
  bit          m_mis [2];
  int          m_cnt [2];
  int          m_end [2] = '{0, 1};
  int          m_max [2] = '{65535, 7};
  bit          m_valid = 1'b0;

  pc_ctrl #(.WORD_LEN(32), .MEM_DEPTH(4), .INSTR_BYTES(4), .END_MODE(0),
            .RESET_ADDR(32'd0), .CNT_W(16)) dut_h (
    .i_CLK(clk), .i_RST(rst), .i_EN(en), .i_REDIRECT(redir), .i_TARGET(tgt),
    .i_RESUME(resume), .o_PC(pc_h), .o_PC_NEXT_SEQ(nxt_h), .o_HALTED(halt_h),
    .o_MISALIGNED(mis_h), .o_INSTR_CNT(cnt_h));

  pc_ctrl #(.WORD_LEN(32), .MEM_DEPTH(4), .INSTR_BYTES(4), .END_MODE(1),
            .RESET_ADDR(32'd0), .CNT_W(3)) dut_w (
    .i_CLK(clk), .i_RST(rst), .i_EN(en), .i_REDIRECT(redir), .i_TARGET(tgt),
    .i_RESUME(resume), .o_PC(pc_w), .o_PC_NEXT_SEQ(nxt_w), .o_HALTED(halt_w),
    .o_MISALIGNED(mis_w), .o_INSTR_CNT(cnt_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bump(input int k);
    if (m_cnt[k] < m_max[k]) m_cnt[k] = m_cnt[k] + 1;
  endtask

  task automatic mdl_step(input int k);
    logic [31:0] t;
    t = tgt & ~32'd3;
    if (rst) begin
      m_pc[k] = 32'd0; m_h[k] = 1'b0; m_mis[k] = 1'b0; m_cnt[k] = 0;
    end else begin
      m_mis[k] = 1'b0;
      if (m_h[k]) begin
        if (resume) begin
          if (!redir) begin
            m_pc[k] = 32'd0; m_h[k] = 1'b0;
          end else if (t > LAST && m_end[k] == 0) begin
            m_pc[k] = LAST;
          end else begin
            m_pc[k] = (t > LAST) ? 32'd0 : t; m_h[k] = 1'b0;
          end
        end
      end else if (en) begin
        if (redir) begin
          m_mis[k] = (tgt[1:0] != 2'd0);
          if (t > LAST) begin
            if (m_end[k] == 0) begin m_pc[k] = LAST; m_h[k] = 1'b1; end
            else m_pc[k] = 32'd0;
          end else begin
            m_pc[k] = t;
          end
          bump(k);
        end else if (m_pc[k] == LAST) begin
          if (m_end[k] == 0) m_h[k] = 1'b1;
          else begin m_pc[k] = 32'd0; bump(k); end
        end else begin
          m_pc[k] = m_pc[k] + 32'd4;
          bump(k);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    mdl_step(0);
    mdl_step(1);
    if (rst) m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("h_pc",  pc_h,          m_pc[0]);
      chk("h_nxt", nxt_h,         m_pc[0] + 32'd4);
      chk("h_hlt", 32'(halt_h),   32'(m_h[0]));
      chk("h_mis", 32'(mis_h),    32'(m_mis[0]));
      chk("h_cnt", 32'(cnt_h),    32'(m_cnt[0]));
      chk("w_pc",  pc_w,          m_pc[1]);
      chk("w_nxt", nxt_w,         m_pc[1] + 32'd4);
      chk("w_hlt", 32'(halt_w),   32'(m_h[1]));
      chk("w_mis", 32'(mis_w),    32'(m_mis[1]));
      chk("w_cnt", 32'(cnt_w),    32'(m_cnt[1]));
    end
  end

  task automatic step(input logic e, input logic r, input logic [31:0] t,
                      input logic res, input logic rs);
    en = e; redir = r; tgt = t; resume = res; rst = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_h [6];
    logic [31:0] exp_w [6];
    logic        exp_hh[6];
    exp_h  = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd12, 32'd12};
    exp_w  = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd0, 32'd4};
    exp_hh = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    en = 0; redir = 0; tgt = 0; resume = 0; rst = 1;
    @(negedge clk);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("rst_pc",   pc_h, 32'd0);
    chk("rst_cnt",  32'(cnt_h), 32'd0);
    chk("rst_hlt",  32'(halt_h), 32'd0);
    chk("rst_mis",  32'(mis_h), 32'd0);
    chk("mdl_rst",  m_pc[0], 32'd0);

    // halt at end vs wrap, six enabled cycles
    for (int i = 0; i < 6; i++) begin
      chk("seq_h_pc",  pc_h, exp_h[i]);
      chk("seq_w_pc",  pc_w, exp_w[i]);
      chk("seq_h_hlt", 32'(halt_h), 32'(exp_hh[i]));
      chk("seq_w_hlt", 32'(halt_w), 32'd0);
      if (i == 4) chk("wrap_cnt", 32'(cnt_w), 32'd4);
      step(1, 0, 0, 0, 0);
    end
    chk("halt_pc",  pc_h, 32'd12);
    chk("halt_hlt", 32'(halt_h), 32'd1);
    chk("halt_cnt", 32'(cnt_h), 32'd3);
    chk("mdl_halt_cnt", 32'(m_cnt[0]), 32'd3);
    chk("w_pc6",    pc_w, 32'd8);
    chk("w_cnt6",   32'(cnt_w), 32'd6);

    // stall wins over redirect
    step(0, 1, 32'd8, 0, 0);
    chk("stall_pc",  pc_w, 32'd8);
    chk("stall_cnt", 32'(cnt_w), 32'd6);
    chk("stall_h",   pc_h, 32'd12);

    // resume with redirect
    step(0, 1, 32'd4, 1, 0);
    chk("res_pc",  pc_h, 32'd4);
    chk("res_hlt", 32'(halt_h), 32'd0);
    chk("res_cnt", 32'(cnt_h), 32'd3);
    chk("res_w",   pc_w, 32'd8);

    // misaligned redirect
    step(1, 1, 32'h0000_0006, 0, 0);
    chk("mis_pc",   pc_h, 32'd4);
    chk("mis_h",    32'(mis_h), 32'd1);
    chk("mis_w",    32'(mis_w), 32'd1);
    chk("mis_cnt",  32'(cnt_h), 32'd4);
    chk("mis_wcnt", 32'(cnt_w), 32'd7);
    step(0, 0, 0, 0, 0);
    chk("mis_end",  32'(mis_h), 32'd0);

    // counter saturation on the narrow counter, halt again on the other
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    chk("sat_wcnt", 32'(cnt_w), 32'd7);
    chk("sat_wpc",  pc_w, 32'd0);
    chk("h2_hlt",   32'(halt_h), 32'd1);
    chk("h2_cnt",   32'(cnt_h), 32'd6);

    // resume without redirect returns to RESET_ADDR
    step(0, 0, 0, 1, 0);
    chk("res0_pc",  pc_h, 32'd0);
    chk("res0_hlt", 32'(halt_h), 32'd0);
    chk("res0_cnt", 32'(cnt_h), 32'd6);

    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    chk("h3_hlt", 32'(halt_h), 32'd1);
    chk("h3_cnt", 32'(cnt_h), 32'd9);

    // reset while halted and resuming
    step(1, 1, 32'd4, 1, 1);
    chk("rh_pc",   pc_h, 32'd0);
    chk("rh_cnt",  32'(cnt_h), 32'd0);
    chk("rh_hlt",  32'(halt_h), 32'd0);
    chk("rh_wcnt", 32'(cnt_w), 32'd0);

    // reset during a misaligned redirect leaves no pulse
    step(1, 1, 32'h0000_0005, 0, 1);
    chk("rm_mis", 32'(mis_h), 32'd0);
    chk("rm_pc",  pc_h, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("rm_mis2", 32'(mis_w), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter WORD_LEN, default 32, PC/address width in bits.
REQ-002 SHALL have parameter MEM_DEPTH, default 64, instruction memory depth in words.
REQ-003 SHALL have parameter INSTR_BYTES, default 4, byte stride per instruction (power of two).
REQ-004 SHALL have parameter END_MODE, default 0, end-of-memory policy: 0 = halt, 1 = wrap.
REQ-005 SHALL have parameter RESET_ADDR, default 0, PC value after reset.
REQ-006 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-007 SHALL have port i_CLK  in  1  single clock; all state changes on its rising edge.
REQ-008 SHALL have port i_RST  in  1  synchronous, active-high reset.
REQ-009 SHALL have port i_EN  in  1  advance enable; low = stall, PC holds.
REQ-010 SHALL have port i_REDIRECT  in  1  branch/jump taken this cycle.
REQ-011 SHALL have port i_TARGET  in  WORD_LEN  redirect byte address.
REQ-012 SHALL have port i_RESUME  in  1  leave HALT (one-cycle pulse).
REQ-013 SHALL have port o_PC  out  WORD_LEN  registered current PC.
REQ-014 SHALL have port o_PC_NEXT_SEQ  out  WORD_LEN  o_PC + INSTR_BYTES, modulo 2^WORD_LEN, combinational.
REQ-015 SHALL have port o_HALTED  out  1  high while in HALT.
REQ-016 SHALL have port o_MISALIGNED  out  1  one-cycle pulse: accepted redirect had nonzero low bits.
REQ-017 SHALL have port o_INSTR_CNT  out  CNT_W  count of PC advances since reset.

Function
REQ-018 SHALL define LAST = (MEM_DEPTH-1)*INSTR_BYTES.
REQ-019 SHALL implement a two-state FSM: RUN and HALT.
REQ-020 SHALL, in RUN with i_EN=0, hold o_PC and o_INSTR_CNT, and ignore i_REDIRECT.
REQ-021 SHALL, in RUN with i_EN=1 and i_REDIRECT=1, load i_TARGET with its low log2(INSTR_BYTES) bits forced to zero on the next edge.
REQ-022 SHALL, on such a load with a nonzero masked-off bit, assert o_MISALIGNED for exactly the following cycle.
REQ-023 SHALL, on a redirect target above LAST, load LAST and enter HALT when END_MODE=0, or load RESET_ADDR when END_MODE=1.
REQ-024 SHALL, in RUN with i_EN=1 and no redirect, load o_PC_NEXT_SEQ when o_PC < LAST.
REQ-025 SHALL, on a sequential advance from o_PC = LAST, hold LAST and enter HALT when END_MODE=0, or load RESET_ADDR and stay in RUN when END_MODE=1.
REQ-026 SHALL keep o_PC equal to LAST in HALT and ignore i_EN and i_REDIRECT there.
REQ-027 SHALL, in HALT on i_RESUME=1, go to RUN and load i_TARGET (masked) if i_REDIRECT=1, otherwise RESET_ADDR.
REQ-028 SHALL ignore i_RESUME in RUN.
REQ-029 SHALL increment o_INSTR_CNT on every edge on which o_PC is loaded in RUN, saturating at all-ones.
REQ-030 SHALL not increment o_INSTR_CNT on the HALT-entry hold or the resume load.
REQ-031 SHALL apply this priority: i_RST > HALT/resume > stall > redirect > sequential.
REQ-032 SHALL reflect every update one cycle after the qualifying edge; combinational input-to-o_PC paths are prohibited.

Reset
REQ-033 SHALL, on a rising edge with i_RST=1, set o_PC=RESET_ADDR, state=RUN, o_HALTED=0, o_MISALIGNED=0 and o_INSTR_CNT=0, overriding all other inputs.
REQ-034 SHALL, on reset asserted in HALT or mid-redirect, abandon the pending operation with no residual pulse.

Structure
REQ-035 SHALL place the FSM state encoding and the END_MODE_HALT/END_MODE_WRAP constants in shared package pc_pkg.
REQ-036 SHALL isolate next-PC selection (masking, LAST compare, wrap/clamp) in combinational sub-module pc_next_sel.
REQ-037 SHALL keep all state registers in pc_ctrl.

Verification
REQ-038 SHALL cover halt at end: MEM_DEPTH=4, END_MODE=0, i_EN=1 for 6 cycles -> o_PC 0,4,8,12,12,12; o_HALTED=1 from the cycle after o_PC first equals 12; o_INSTR_CNT=3.
REQ-039 SHALL cover wrap: MEM_DEPTH=4, END_MODE=1, i_EN=1 for 5 cycles -> o_PC 0,4,8,12,0; o_HALTED stays 0; o_INSTR_CNT=4.
REQ-040 SHALL cover misaligned redirect: i_REDIRECT=1, i_TARGET=0x0000_0006 -> o_PC=4 next cycle; o_MISALIGNED high for one cycle.
REQ-041 SHALL cover stall vs redirect: i_EN=0, i_REDIRECT=1, i_TARGET=8 -> o_PC unchanged, o_INSTR_CNT unchanged.
REQ-042 SHALL cover resume: in HALT, i_RESUME=1, i_REDIRECT=1, i_TARGET=4 -> o_PC=4, o_HALTED=0 next cycle.
REQ-043 SHALL cover reset in HALT: i_RST=1 in the same cycle as i_RESUME=1 -> o_PC=RESET_ADDR, o_INSTR_CNT=0, o_HALTED=0.
